// File: rtl/output_stage_ctrl_pkg.sv
// Shared types and saturation limits for the requantising output-stage sequencer.
package output_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACC,
        FETCH,
        EXEC,
        LAT,
        EMIT,
        DONE
    } osc_state_t;

    localparam int S8_MAX = 127;
    localparam int S8_MIN = -128;

endpackage

// File: rtl/output_stage_ctrl.sv
// Sequences the output stage of one linear layer, one neuron at a time, and streams the results.
// Optional build macro OUTPUT_STAGE_CLAMP_EN: saturate os_long_out instead of truncating os_out.
module output_stage_ctrl
    import output_stage_ctrl_pkg::*;
#(
    parameter int N_NEURONS      = 10,
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int OS_LATENCY     = 1,
    parameter int ADDR_W         = $clog2(N_NEURONS > 1 ? N_NEURONS : 2)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIAS_PRECISION-1:0] ai_in,
    input  logic                      acc_valid,
    output logic                      acc_ready,
    input  logic [BIAS_PRECISION-1:0] acc_data,
    output logic [ADDR_W-1:0]         bias_addr,
    input  logic [BIAS_PRECISION-1:0] bias_data,
    output logic                      os_ce,
    output logic [BIAS_PRECISION-1:0] os_ai,
    output logic [BIAS_PRECISION-1:0] os_acc,
    output logic [BIAS_PRECISION-1:0] os_bias,
    input  logic [PRECISION-1:0]      os_out,
`ifdef OUTPUT_STAGE_CLAMP_EN
    input  logic [BIAS_PRECISION-1:0] os_long_out,
`endif
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [PRECISION-1:0]      res_data,
    output logic                      res_last,
    output logic                      busy,
    output logic                      done
);

    localparam int                 CNT_W    = $clog2(OS_LATENCY > 1 ? OS_LATENCY : 2);
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(N_NEURONS - 1);
    localparam logic [CNT_W-1:0]   LAT_LOAD = CNT_W'(OS_LATENCY - 1);

    osc_state_t           state;
    osc_state_t           state_nxt;
    logic [ADDR_W-1:0]    idx;
    logic [CNT_W-1:0]     lat_cnt;
    logic [PRECISION-1:0] result;

`ifdef OUTPUT_STAGE_CLAMP_EN
    logic signed [BIAS_PRECISION-1:0] long_s;

    assign long_s = os_long_out;

    always_comb begin
        if (long_s > $signed(BIAS_PRECISION'(S8_MAX))) begin
            result = PRECISION'(S8_MAX);
        end else if (long_s < $signed(BIAS_PRECISION'(S8_MIN))) begin
            result = PRECISION'(S8_MIN);
        end else begin
            result = os_long_out[PRECISION-1:0];
        end
    end
`else
    assign result = os_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_ready = 1'b0;
        os_ce     = 1'b0;
        res_valid = 1'b0;
        res_last  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        bias_addr = idx;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_ACC;
            end
            WAIT_ACC: begin
                acc_ready = 1'b1;
                if (acc_valid) state_nxt = FETCH;
            end
            FETCH: state_nxt = EXEC;
            EXEC: begin
                os_ce     = 1'b1;
                state_nxt = LAT;
            end
            LAT: begin
                if (lat_cnt == '0) state_nxt = EMIT;
            end
            EMIT: begin
                res_valid = 1'b1;
                res_last  = (idx == LAST_IDX);
                if (res_ready) state_nxt = (idx == LAST_IDX) ? DONE : WAIT_ACC;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers stay untouched from EXEC through EMIT so the output stage sees a stable word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            lat_cnt  <= '0;
            os_ai    <= '0;
            os_acc   <= '0;
            os_bias  <= '0;
            res_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        os_ai <= ai_in;
                        idx   <= '0;
                    end
                end
                WAIT_ACC: begin
                    if (acc_valid) os_acc <= acc_data;
                end
                FETCH: os_bias <= bias_data;
                EXEC:  lat_cnt <= LAT_LOAD;
                LAT: begin
                    if (lat_cnt == '0) begin
                        res_data <= result;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                EMIT: begin
                    if (res_ready && (idx != LAST_IDX)) idx <= idx + 1'b1;
                end
                DONE: idx <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_stage_ctrl.sv
// Self-checking bench for output_stage_ctrl: transaction-level model, bias ROM and output-stage stand-ins.
// Build with OUTPUT_STAGE_CLAMP_EN defined to exercise the saturating result path.
module tb_output_stage_ctrl;

    localparam int N      = 3;
    localparam int PREC   = 8;
    localparam int BP     = 32;
    localparam int OS_LAT = 1;
    localparam int AW     = $clog2(N > 1 ? N : 2);
    localparam int EMIT_K = 3 + OS_LAT;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            acc_valid = 1'b0;
    logic            res_ready = 1'b0;
    logic [BP-1:0]   ai_in = '0;
    logic [BP-1:0]   acc_data = '0;
    logic [BP-1:0]   bias_data;
    logic [PREC-1:0] os_out;
    logic            acc_ready, os_ce, res_valid, res_last, busy, done;
    logic [AW-1:0]   bias_addr;
    logic [BP-1:0]   os_ai, os_acc, os_bias;
    logic [PREC-1:0] res_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit fix_data = 0;
    logic [BP-1:0] rom [N];
    int tgt [N] = '{300, -200, 5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    output_stage_ctrl #(
        .N_NEURONS(N), .PRECISION(PREC), .BIAS_PRECISION(BP), .OS_LATENCY(OS_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ai_in(ai_in),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .bias_addr(bias_addr), .bias_data(bias_data),
        .os_ce(os_ce), .os_ai(os_ai), .os_acc(os_acc), .os_bias(os_bias), .os_out(os_out),
`ifdef OUTPUT_STAGE_CLAMP_EN
        .os_long_out(long_out),
`endif
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .done(done)
    );

    // Synchronous bias ROM and an output stage whose result is only meaningful OS_LAT cycles after os_ce.
    always @(posedge clk) bias_data <= rom[bias_addr];

    always @(posedge clk) begin
        if (os_ce) os_out <= PREC'(os_ai + os_acc + os_bias);
        else       os_out <= PREC'($urandom);
    end

`ifdef OUTPUT_STAGE_CLAMP_EN
    logic [BP-1:0] long_out;
    always @(posedge clk) begin
        if (os_ce) long_out <= os_ai + os_acc + os_bias;
        else       long_out <= BP'($urandom_range(200)) - BP'(100);
    end
`endif

    function automatic logic [PREC-1:0] expectRes(input logic [BP-1:0] sum);
`ifdef OUTPUT_STAGE_CLAMP_EN
        int s = $signed(sum);
        if (s > 127)  return PREC'(127);
        if (s < -128) return PREC'(8'h80);
        return sum[PREC-1:0];
`else
        return sum[PREC-1:0];
`endif
    endfunction

    // Reference model: m_k counts cycles since the accumulator word was accepted (0 = waiting for it).
    bit              m_active, m_done;
    int              m_k, m_n;
    logic [BP-1:0]   m_ai, m_acc, m_bias;
    logic [PREC-1:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0; m_done <= 0; m_k <= 0; m_n <= 0;
            m_ai <= '0; m_acc <= '0; m_bias <= '0; m_res <= '0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1; m_ai <= ai_in; m_n <= 0; m_k <= 0;
            end
        end else if (m_k == 0) begin
            if (acc_valid) begin
                m_acc <= acc_data; m_k <= 1;
            end
        end else if (m_k < EMIT_K) begin
            m_k <= m_k + 1;
            if (m_k == 1) m_bias <= rom[m_n];
            if (m_k == EMIT_K - 1) m_res <= expectRes(m_ai + m_acc + m_bias);
        end else if (res_ready) begin
            if (m_n == N - 1) begin
                m_active <= 0; m_done <= 1;
            end else begin
                m_n <= m_n + 1; m_k <= 0;
            end
        end
    end

    logic exp_wait, exp_emit;
    assign exp_wait = m_active && (m_k == 0);
    assign exp_emit = m_active && (m_k == EMIT_K);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("busy", 32'(busy), 32'(m_active || m_done));
            checkOutput("acc_ready", 32'(acc_ready), 32'(exp_wait));
            checkOutput("os_ce", 32'(os_ce), 32'(m_active && (m_k == 2)));
            checkOutput("res_valid", 32'(res_valid), 32'(exp_emit));
            checkOutput("res_last", 32'(res_last), 32'(exp_emit && (m_n == N - 1)));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("os_ai", os_ai, m_ai);
            checkOutput("os_acc", os_acc, m_acc);
            checkOutput("os_bias", os_bias, m_bias);
            if (exp_wait) checkOutput("bias_addr", 32'(bias_addr), 32'(m_n));
            if (exp_emit) checkOutput("res_data", 32'(res_data), 32'(m_res));
        end
    end

    task automatic applyStimulus(input bit s, input bit av, input bit rr);
        start = s; acc_valid = av; res_ready = rr;
        if (fix_data) begin
            ai_in = '0;
            acc_data = BP'(tgt[m_n]) - rom[m_n];
        end else begin
            ai_in = $urandom;
            acc_data = $urandom;
        end
        @(posedge clk); #1;
    endtask

    task automatic finishSample(input string tag);
        bit seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (done) seen = 1;
            else applyStimulus(0, 1, 1);
        end
        checkOutput(tag, 32'(seen), 32'(1));
        applyStimulus(0, 1, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, nres, nd, dcyc;
        bit seen;
        int rcyc [3];
        bit rlast [3];
        logic [PREC-1:0] held;
        logic [PREC-1:0] r4 [3];
        logic [PREC-1:0] exp4 [3];

        for (int i = 0; i < N; i++) rom[i] = $urandom;
`ifdef OUTPUT_STAGE_CLAMP_EN
        exp4 = '{8'h7F, 8'h80, 8'h05};
`else
        exp4 = '{8'h2C, 8'h38, 8'h05};
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_acc_ready", 32'(acc_ready), 0);
        checkOutput("rst_res_valid", 32'(res_valid), 0);
        checkOutput("rst_os_ai", os_ai, 0);
        checkOutput("rst_res_data", 32'(res_data), 0);
        rst_n = 1'b1;
        applyStimulus(0, 1, 1);

        $display("[TB] streaming sample, no stalls");
        c0 = cyc; nres = 0; seen = 0; dcyc = 0;
        applyStimulus(1, 1, 1);
        for (int t = 0; t < 40 && !seen; t++) begin
            if (res_valid && res_ready) begin
                if (nres < 3) begin
                    rcyc[nres] = cyc - c0;
                    rlast[nres] = res_last;
                end
                nres++;
            end
            if (done) begin
                seen = 1; dcyc = cyc - c0;
            end else begin
                applyStimulus(0, 1, 1);
            end
        end
        checkOutput("t1_done_seen", 32'(seen), 1);
        checkOutput("t1_count", 32'(nres), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t1_res_cycle", 32'(rcyc[i]), 32'(5 * (i + 1)));
            checkOutput("t1_res_last", 32'(rlast[i]), 32'(i == 2));
        end
        checkOutput("t1_done_cycle", 32'(dcyc), 16);
        applyStimulus(0, 1, 1);

        $display("[TB] result backpressure");
        applyStimulus(1, 1, 0);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (res_valid) seen = 1;
            else applyStimulus(0, 1, 0);
        end
        checkOutput("t2_reach_emit", 32'(seen), 1);
        held = res_data;
        for (int t = 0; t < 7; t++) begin
            applyStimulus(0, 1, 0);
            checkOutput("t2_valid_held", 32'(res_valid), 1);
            checkOutput("t2_data_stable", 32'(res_data), 32'(held));
            checkOutput("t2_acc_ready_low", 32'(acc_ready), 0);
        end
        finishSample("t2_done_seen");

        $display("[TB] accumulator starvation");
        applyStimulus(1, 0, 1);
        for (int t = 0; t < 10; t++) begin
            applyStimulus(0, 0, 1);
            checkOutput("t3_acc_ready", 32'(acc_ready), 1);
            checkOutput("t3_os_ce", 32'(os_ce), 0);
            checkOutput("t3_bias_addr", 32'(bias_addr), 0);
        end
        finishSample("t3_done_seen");

        $display("[TB] saturation targets");
        fix_data = 1;
        applyStimulus(1, 1, 1);
        nres = 0; seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            if (res_valid && res_ready && nres < 3) begin
                r4[nres] = res_data;
                nres++;
            end
            if (done) seen = 1;
            else applyStimulus(0, 1, 1);
        end
        fix_data = 0;
        checkOutput("t4_count", 32'(nres), 3);
        for (int i = 0; i < 3; i++) checkOutput("t4_res_data", 32'(r4[i]), 32'(exp4[i]));
        applyStimulus(0, 1, 1);

        $display("[TB] asynchronous reset during latency wait");
        applyStimulus(1, 1, 1);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (m_active && m_n == 1 && m_k == 3) seen = 1;
            else applyStimulus(0, 1, 1);
        end
        checkOutput("t5_reach_lat", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_os_ce", 32'(os_ce), 0);
        checkOutput("t5_res_valid", 32'(res_valid), 0);
        checkOutput("t5_os_ai", os_ai, 0);
        checkOutput("t5_os_acc", os_acc, 0);
        checkOutput("t5_os_bias", os_bias, 0);
        checkOutput("t5_res_data", 32'(res_data), 0);
        checkOutput("t5_bias_addr", 32'(bias_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1, 1, 1);
        checkOutput("t5_restart_addr", 32'(bias_addr), 0);
        checkOutput("t5_restart_ready", 32'(acc_ready), 1);
        finishSample("t5_done_seen");

        $display("[TB] start pulses while busy");
        applyStimulus(1, 1, 1);
        nres = 0; nd = 0;
        for (int t = 0; t < 60; t++) begin
            if (res_valid && res_ready) nres++;
            if (done) nd++;
            applyStimulus(res_valid || done, 1, 1);
        end
        checkOutput("t6_results", 32'(nres), 3);
        checkOutput("t6_dones", 32'(nd), 1);
        checkOutput("t6_idle", 32'(busy), 0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 800; t++) begin
            applyStimulus($urandom_range(7) == 0, $urandom_range(3) != 0, $urandom_range(3) != 0);
        end
        for (int t = 0; t < 60; t++) applyStimulus(0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
